// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, ALU selects, FSM states.
// The HALT state only exists when CTRL_ILLEGAL_TRAP_EN is defined.
package ctrl_pkg;

    localparam logic [7:0] OP_LOADI = 8'd0;
    localparam logic [7:0] OP_MOV   = 8'd1;
    localparam logic [7:0] OP_ADD   = 8'd2;
    localparam logic [7:0] OP_SUB   = 8'd3;
    localparam logic [7:0] OP_AND   = 8'd4;
    localparam logic [7:0] OP_OR    = 8'd5;
    localparam logic [7:0] OP_J     = 8'd6;
    localparam logic [7:0] OP_BEQ   = 8'd7;
    localparam logic [7:0] OP_LWD   = 8'd8;
    localparam logic [7:0] OP_LWI   = 8'd9;
    localparam logic [7:0] OP_SWD   = 8'd10;
    localparam logic [7:0] OP_SWI   = 8'd11;

    localparam logic [2:0] ALU_FWD = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    // ST_MERR is the single abort cycle after a memory timeout
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_MERR   = 3'd5
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        ST_HALT   = 3'd6
`endif
    } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode into the static (state-independent) control fields.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 8,
    parameter int ALUOP_W  = 3
) (
    input  logic [OPCODE_W-1:0] opcode_s,
    output logic [ALUOP_W-1:0]  aluop_s,
    output logic                muxcomp_s,
    output logic                muximm_s,
    output logic                is_mem_s,
    output logic                is_load_s,
    output logic                is_branch_s,
    output logic                legal_s
);

    // Opcode table; anything not listed, including nonzero upper bits, is illegal
    always_comb begin
        aluop_s     = ALUOP_W'(ALU_FWD);
        muxcomp_s   = 1'b0;
        muximm_s    = 1'b0;
        is_mem_s    = 1'b0;
        is_load_s   = 1'b0;
        is_branch_s = 1'b0;
        legal_s     = 1'b1;
        case (opcode_s)
            OPCODE_W'(OP_LOADI): muximm_s = 1'b1;
            OPCODE_W'(OP_MOV):   aluop_s  = ALUOP_W'(ALU_FWD);
            OPCODE_W'(OP_ADD):   aluop_s  = ALUOP_W'(ALU_ADD);
            OPCODE_W'(OP_SUB): begin
                aluop_s   = ALUOP_W'(ALU_ADD);
                muxcomp_s = 1'b1;
            end
            OPCODE_W'(OP_AND):   aluop_s  = ALUOP_W'(ALU_AND);
            OPCODE_W'(OP_OR):    aluop_s  = ALUOP_W'(ALU_OR);
            OPCODE_W'(OP_J), OPCODE_W'(OP_BEQ): begin
                aluop_s     = ALUOP_W'(ALU_ADD);
                muxcomp_s   = 1'b1;
                is_branch_s = 1'b1;
            end
            OPCODE_W'(OP_LWD): begin
                is_mem_s  = 1'b1;
                is_load_s = 1'b1;
            end
            OPCODE_W'(OP_LWI): begin
                is_mem_s  = 1'b1;
                is_load_s = 1'b1;
                muximm_s  = 1'b1;
            end
            OPCODE_W'(OP_SWD):   is_mem_s = 1'b1;
            OPCODE_W'(OP_SWI): begin
                is_mem_s = 1'b1;
                muximm_s = 1'b1;
            end
            default:             legal_s  = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle sequencing control unit: FETCH/DECODE/EXEC/MEM/WB with BUSYWAIT timeout.
// Optional feature CTRL_ILLEGAL_TRAP_EN adds the ILLEGAL output and a sticky HALT state.
module control_fsm
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 8,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [OPCODE_W-1:0] OPCODE,
    input  logic                INSTR_VALID,
    input  logic                ZERO,
    input  logic                BUSYWAIT,
    output logic                INSTR_READY,
    output logic [ALUOP_W-1:0]  ALUOP,
    output logic                WRITEENABLE,
    output logic                MUXCOMP,
    output logic                MUXIMM,
    output logic                MUXMEM,
    output logic                JUMP,
    output logic                BRANCH_TAKEN,
    output logic                READ,
    output logic                WRITE,
    output logic                PC_UPDATE,
    output logic                MEM_ERR
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                ILLEGAL
`endif
);

    localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 32'sd0);

    state_t              state_r, state_s;
    logic [OPCODE_W-1:0] ir_r, ir_s;
    logic [15:0]         cnt_r, cnt_s;
    logic                first_r, first_s;
    logic                illegal_r, illegal_s;

    logic [ALUOP_W-1:0]  aluop_s;
    logic                muxcomp_s, muximm_s, is_mem_s, is_load_s, is_branch_s, legal_s;
    logic                timeout_s;
    logic                datapath_s;

    ctrl_decode #(
        .OPCODE_W (OPCODE_W),
        .ALUOP_W  (ALUOP_W)
    ) u_decode (
        .opcode_s    (ir_r),
        .aluop_s     (aluop_s),
        .muxcomp_s   (muxcomp_s),
        .muximm_s    (muximm_s),
        .is_mem_s    (is_mem_s),
        .is_load_s   (is_load_s),
        .is_branch_s (is_branch_s),
        .legal_s     (legal_s)
    );

    // Abort once this busy cycle would bring the busy count up to the limit
    assign timeout_s = TIMEOUT_EN && (({1'b0, cnt_r} + 17'd1) >= 17'(MEM_TIMEOUT));

    // State, instruction and timeout registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r   <= ST_FETCH;
            ir_r      <= '0;
            cnt_r     <= 16'd0;
            first_r   <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            ir_r      <= ir_s;
            cnt_r     <= cnt_s;
            first_r   <= first_s;
            illegal_r <= illegal_s;
        end
    end

    // Next-state logic; the MEM entry cycle (first_r) can never leave MEM
    always_comb begin
        state_s   = state_r;
        ir_s      = ir_r;
        cnt_s     = cnt_r;
        first_s   = 1'b0;
        illegal_s = illegal_r;
        case (state_r)
            ST_FETCH: begin
                if (INSTR_VALID) begin
                    ir_s    = OPCODE;
                    state_s = ST_DECODE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DECODE: state_s = ST_EXEC;
            ST_EXEC: begin
                if (!legal_s) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    illegal_s = 1'b1;
                    state_s   = ST_HALT;
`else
                    state_s   = ST_FETCH;
`endif
                end else if (is_mem_s) begin
                    cnt_s   = 16'd0;
                    first_s = 1'b1;
                    state_s = ST_MEM;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (BUSYWAIT && (cnt_r != 16'hFFFF)) begin
                    cnt_s = cnt_r + 16'd1;
                end else begin
                    cnt_s = cnt_r;
                end
                if (first_r) begin
                    state_s = ST_MEM;
                end else if (!BUSYWAIT) begin
                    state_s = is_load_s ? ST_WB : ST_FETCH;
                end else if (timeout_s) begin
                    state_s = ST_MERR;
                end else begin
                    state_s = ST_MEM;
                end
            end
            ST_WB:   state_s = ST_FETCH;
            ST_MERR: state_s = ST_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
            ST_HALT: state_s = ST_HALT;
`endif
            default: state_s = ST_FETCH;
        endcase
    end

    assign datapath_s = (state_r == ST_DECODE) || (state_r == ST_EXEC) ||
                        (state_r == ST_MEM)    || (state_r == ST_WB);

    // Output decode from the registered state and IR
    always_comb begin
        INSTR_READY  = 1'b0;
        ALUOP        = '0;
        WRITEENABLE  = 1'b0;
        MUXCOMP      = 1'b0;
        MUXIMM       = 1'b0;
        MUXMEM       = 1'b0;
        JUMP         = 1'b0;
        BRANCH_TAKEN = 1'b0;
        READ         = 1'b0;
        WRITE        = 1'b0;
        PC_UPDATE    = 1'b0;
        MEM_ERR      = 1'b0;
        if (datapath_s) begin
            ALUOP   = aluop_s;
            MUXCOMP = muxcomp_s;
            MUXIMM  = muximm_s;
        end else begin
            ALUOP   = '0;
        end
        case (state_r)
            ST_FETCH: INSTR_READY = 1'b1;
            ST_EXEC: begin
                if (!legal_s) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    PC_UPDATE = 1'b0;
`else
                    PC_UPDATE = 1'b1;
`endif
                end else if (is_branch_s) begin
                    JUMP         = (ir_r == OPCODE_W'(OP_J));
                    BRANCH_TAKEN = (ir_r == OPCODE_W'(OP_BEQ)) && ZERO;
                    PC_UPDATE    = 1'b1;
                end else if (!is_mem_s) begin
                    WRITEENABLE = 1'b1;
                    PC_UPDATE   = 1'b1;
                end else begin
                    PC_UPDATE = 1'b0;
                end
            end
            ST_MEM: begin
                READ      = is_load_s;
                WRITE     = !is_load_s;
                PC_UPDATE = !is_load_s && !first_r && !BUSYWAIT;
            end
            ST_WB: begin
                WRITEENABLE = 1'b1;
                MUXMEM      = 1'b1;
                PC_UPDATE   = 1'b1;
            end
            ST_MERR: begin
                MEM_ERR   = 1'b1;
                PC_UPDATE = 1'b1;
            end
            default: INSTR_READY = 1'b0;
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign ILLEGAL = illegal_r;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: per-instruction expected output traces built
// from the instruction semantics, compared every cycle, plus literal count checks.
module tb_control_fsm;

    localparam int TMO = 5;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] OPCODE = 8'd0;
    logic       INSTR_VALID = 1'b0;
    logic       ZERO = 1'b0;
    logic       BUSYWAIT = 1'b0;
    logic       INSTR_READY, WRITEENABLE, MUXCOMP, MUXIMM, MUXMEM, JUMP, BRANCH_TAKEN;
    logic       READ, WRITE, PC_UPDATE, MEM_ERR;
    logic [2:0] ALUOP;
    logic       ill_w;

    always #5 CLK = ~CLK;

    control_fsm #(.OPCODE_W(8), .ALUOP_W(3), .MEM_TIMEOUT(TMO)) dut (
        .CLK(CLK), .RESET(RESET), .OPCODE(OPCODE), .INSTR_VALID(INSTR_VALID),
        .ZERO(ZERO), .BUSYWAIT(BUSYWAIT), .INSTR_READY(INSTR_READY), .ALUOP(ALUOP),
        .WRITEENABLE(WRITEENABLE), .MUXCOMP(MUXCOMP), .MUXIMM(MUXIMM), .MUXMEM(MUXMEM),
        .JUMP(JUMP), .BRANCH_TAKEN(BRANCH_TAKEN), .READ(READ), .WRITE(WRITE),
        .PC_UPDATE(PC_UPDATE), .MEM_ERR(MEM_ERR)
`ifdef CTRL_ILLEGAL_TRAP_EN
        , .ILLEGAL(ill_w)
`endif
    );
`ifndef CTRL_ILLEGAL_TRAP_EN
    assign ill_w = 1'b0;
`endif

    typedef struct packed {
        logic       ready;
        logic [2:0] aluop;
        logic       we, comp, imm, mmem, jump, br, rd, wr, pc, err, ill;
    } outv_t;

    int checks = 0;
    int failures = 0;
    bit halted = 1'b0;
    int cnt [10];   // observed: rd wr we pc br err mm comp jump notready
    int base [10];
    int aluop_tab [12] = '{0, 0, 1, 1, 2, 3, 1, 1, 0, 0, 0, 0};

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic outv_t idle_v();
        outv_t e = '0;
        e.ready = !halted;
        e.ill   = halted;
        return e;
    endfunction

    function automatic outv_t ctl_v(input logic [7:0] op);
        outv_t e = '0;
        if (op < 8'd12) begin
            e.aluop = 3'(aluop_tab[op]);
            e.comp  = (op == 8'd3) || (op == 8'd6) || (op == 8'd7);
            e.imm   = (op == 8'd0) || (op == 8'd9) || (op == 8'd11);
        end
        return e;
    endfunction

    task automatic cyc(input logic r, input logic v, input logic [7:0] op, input logic z,
                       input logic b, input outv_t e, input bit chk);
        outv_t a;
        @(posedge CLK); #1;
        RESET = r; INSTR_VALID = v; OPCODE = op; ZERO = z; BUSYWAIT = b;
        @(negedge CLK);
        a = '{INSTR_READY, ALUOP, WRITEENABLE, MUXCOMP, MUXIMM, MUXMEM, JUMP,
              BRANCH_TAKEN, READ, WRITE, PC_UPDATE, MEM_ERR, ill_w};
        cnt[0] += int'(a.rd);  cnt[1] += int'(a.wr);  cnt[2] += int'(a.we);
        cnt[3] += int'(a.pc);  cnt[4] += int'(a.br);  cnt[5] += int'(a.err);
        cnt[6] += int'(a.mmem); cnt[7] += int'(a.comp && a.aluop == 3'd1);
        cnt[8] += int'(a.jump); cnt[9] += int'(!a.ready);
        if (chk) begin
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL outputs t=%0t got=%b want=%b (rdy,aluop,we,comp,imm,mm,j,br,rd,wr,pc,err,ill)",
                         $time, a, e);
            end
        end
    endtask

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 10; i++) base[i] = cnt[i];
    endtask

    function automatic int d(input int i);
        return cnt[i] - base[i];
    endfunction

    task automatic do_reset();
        cyc(1'b0, rb(), 8'($urandom), rb(), rb(), idle_v(), 1'b1);
        halted = 1'b0;
    endtask

    // One instruction: nb = busy cycles at MEM start, rst_at = MEM cycle carrying RESET=0
    task automatic run_instr(input logic [7:0] op, input logic z, input int nb,
                             input int pre, input int rst_at);
        outv_t c, e;
        int    lim, ex;
        bit    is_ld, is_st;
        for (int i = 0; i < pre; i++) cyc(1'b1, 1'b0, 8'($urandom), rb(), rb(), idle_v(), 1'b1);
        cyc(1'b1, 1'b1, op, rb(), rb(), idle_v(), 1'b1);
        c = ctl_v(op);
        cyc(1'b1, rb(), 8'($urandom), rb(), rb(), c, 1'b1);
        is_ld = (op == 8'd8) || (op == 8'd9);
        is_st = (op == 8'd10) || (op == 8'd11);
        e = c;
        if (op <= 8'd5) begin e.we = 1'b1; e.pc = 1'b1; end
        else if (op == 8'd6) begin e.jump = 1'b1; e.pc = 1'b1; end
        else if (op == 8'd7) begin e.br = z; e.pc = 1'b1; end
        else if (!is_ld && !is_st) begin
`ifndef CTRL_ILLEGAL_TRAP_EN
            e.pc = 1'b1;
`endif
        end
        cyc(1'b1, rb(), 8'($urandom), z, rb(), e, 1'b1);
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (op > 8'd11) halted = 1'b1;
`endif
        if (is_ld || is_st) begin
            lim = (TMO < 2) ? 2 : TMO;
            ex  = (nb >= lim) ? lim : ((nb + 1 < 2) ? 2 : nb + 1);
            for (int i = 1; i <= ex; i++) begin
                e = c; e.rd = is_ld; e.wr = is_st;
                if (nb < lim && i == ex && is_st) e.pc = 1'b1;
                if (i == rst_at) begin
                    cyc(1'b0, rb(), 8'($urandom), rb(), logic'(i <= nb), e, 1'b1);
                    return;
                end
                cyc(1'b1, rb(), 8'($urandom), rb(), logic'(i <= nb), e, 1'b1);
            end
            if (nb >= lim) begin
                e = '0; e.err = 1'b1; e.pc = 1'b1;
                cyc(1'b1, rb(), 8'($urandom), rb(), rb(), e, 1'b1);
            end else if (is_ld) begin
                e = c; e.we = 1'b1; e.mmem = 1'b1; e.pc = 1'b1;
                cyc(1'b1, rb(), 8'($urandom), rb(), rb(), e, 1'b1);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] op;
        int         nb;
        for (int i = 0; i < 10; i++) cnt[i] = 0;
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, idle_v(), 1'b0);
        do_reset();
        lit("rst_ready", int'(INSTR_READY), 1);
        lit("rst_pc", int'(PC_UPDATE), 0);

        snap(); run_instr(8'd3, 1'b0, 0, 0, 0);
        cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, idle_v(), 1'b1);
        lit("sub_we", d(2), 1); lit("sub_pc", d(3), 1); lit("sub_aluop_comp", d(7), 2);

        snap(); run_instr(8'd7, 1'b1, 0, 1, 0); run_instr(8'd7, 1'b0, 0, 0, 0);
        lit("beq_taken", d(4), 1); lit("beq_pc", d(3), 2);

        snap(); run_instr(8'd6, 1'b0, 0, 0, 0);
        lit("j_jump", d(8), 1); lit("j_pc", d(3), 1);

        snap(); run_instr(8'd8, 1'b0, 4, 0, 0);
        lit("lwd_read", d(0), 5); lit("lwd_we", d(2), 1); lit("lwd_mm", d(6), 1); lit("lwd_pc", d(3), 1);

        snap(); run_instr(8'd11, 1'b0, 100, 0, 0);
        lit("swi_write", d(1), TMO); lit("swi_err", d(5), 1); lit("swi_pc", d(3), 1); lit("swi_we", d(2), 0);

        snap(); run_instr(8'd10, 1'b0, 0, 0, 0);
        lit("swd_write", d(1), 2); lit("swd_pc", d(3), 1);

        snap(); run_instr(8'd8, 1'b0, 100, 0, 3);
        cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, idle_v(), 1'b1);
        lit("rstmem_read", d(0), 3); lit("rstmem_we", d(2), 0); lit("rstmem_pc", d(3), 0);
        snap(); run_instr(8'd0, 1'b0, 0, 0, 0);
        lit("loadi_we", d(2), 1); lit("loadi_pc", d(3), 1);

        snap(); run_instr(8'hFF, 1'b0, 0, 0, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 8'd2, rb(), rb(), idle_v(), 1'b1);
        lit("ill_pc", d(3), 0); lit("ill_flag", int'(ill_w), 1); lit("ill_ready", int'(INSTR_READY), 0);
        do_reset();
        lit("ill_cleared", int'(ill_w), 0);
`else
        lit("ill_pc", d(3), 1); lit("ill_we", d(2), 0);
`endif

        for (int n = 0; n < 150; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(12, 255)) : 8'($urandom_range(0, 11));
            nb = ($urandom_range(0, 7) == 0) ? TMO + 2 : $urandom_range(0, TMO);
            run_instr(op, rb(), nb, $urandom_range(0, 2), 0);
            if (halted) begin
                cyc(1'b1, 1'b1, 8'd1, rb(), rb(), idle_v(), 1'b1);
                do_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Multi-cycle sequencing control unit for the 8-bit single-cycle CPU's successor datapath.
- Accepts an opcode under a valid handshake, latches it, and walks a Moore FSM: FETCH, DECODE, EXEC, MEM, WB.
- Drives ALU, register-file, mux, branch and data-memory controls.
- Stalls on data-memory BUSYWAIT, with a parametrised timeout.

Parameters:
- OPCODE_W, 8, opcode width; upper bits beyond the defined encodings must be zero for a legal opcode.
- ALUOP_W, 3, ALU select width.
- MEM_TIMEOUT, 255, maximum BUSYWAIT-high cycles in MEM before abort; 0 disables the timeout.

Ports:
- CLK in 1: clock, rising edge.
- RESET in 1: synchronous, active-low.
- OPCODE in OPCODE_W: instruction opcode, valid with INSTR_VALID.
- INSTR_VALID in 1: opcode present.
- ZERO in 1: ALU zero flag, sampled in EXEC.
- BUSYWAIT in 1: data memory busy.
- INSTR_READY out 1: FSM in FETCH, able to accept.
- ALUOP out ALUOP_W: 0 fwd, 1 add, 2 and, 3 or.
- WRITEENABLE out 1: register-file write strobe.
- MUXCOMP out 1: 1 selects the two's-complement operand.
- MUXIMM out 1: 1 selects the immediate operand.
- MUXMEM out 1: 1 selects memory read data for writeback.
- JUMP out 1: unconditional PC redirect.
- BRANCH_TAKEN out 1: conditional redirect.
- READ out 1: memory read request.
- WRITE out 1: memory write request.
- PC_UPDATE out 1: one-cycle pulse, instruction retired.
- MEM_ERR out 1: one-cycle pulse on memory timeout.

Behaviour:
- Opcodes:
  - loadi 0: fwd, imm.
  - mov 1: fwd, reg.
  - add 2: add, reg.
  - sub 3: add, comp.
  - and 4, or 5: reg.
  - j 6, beq 7: add, comp.
  - lwd 8, lwi 9 (imm), swd 10, swi 11 (imm).
- All other opcodes are illegal.
- Reset (RESET=0 at a CLK edge): state=FETCH, latched IR=0, timeout count=0. Every output is 0 except INSTR_READY=1. Reset mid-MEM drops READ/WRITE the next cycle and performs no writeback or PC_UPDATE.
- All outputs are Moore, decoded from the registered state and IR. Mux and ALUOP outputs are 0 outside DECODE/EXEC/MEM/WB.
- FETCH: INSTR_READY=1. On an edge with INSTR_VALID=1, latch OPCODE and go to DECODE. INSTR_VALID outside FETCH is ignored.
- DECODE: one cycle. ALUOP and mux selects become valid. Go to EXEC.
- EXEC, ALU op: WRITEENABLE=1 and PC_UPDATE=1; go to FETCH.
- EXEC, j: JUMP=1 and PC_UPDATE=1; go to FETCH.
- EXEC, beq: BRANCH_TAKEN=ZERO and PC_UPDATE=1; go to FETCH.
- EXEC, memory op: go to MEM.
- Latency for ALU and branch ops: accept at edge T, PC_UPDATE high in cycle T+2, INSTR_READY high again in T+3.
- MEM: READ (loads) or WRITE (stores) held high.
  - The entry cycle never exits.
  - Afterwards, exit on the first cycle with BUSYWAIT=0.
  - Loads go to WB. Stores assert PC_UPDATE in the exit cycle, then go to FETCH.
  - READ/WRITE deassert on leaving MEM.
- Timeout: a counter increments in each MEM cycle with BUSYWAIT=1 and clears on MEM entry.
  - If MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT: MEM_ERR=1 and PC_UPDATE=1, go to FETCH, no WB.
  - If BUSYWAIT falls in the same cycle the count hits the limit, normal completion wins.
- WB: WRITEENABLE=1, MUXMEM=1, PC_UPDATE=1; go to FETCH.
- Illegal opcode: treated as a NOP. EXEC pulses PC_UPDATE only (see the optional feature).

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- With the macro defined:
  - Extra output ILLEGAL (1 bit, reset 0).
  - An illegal opcode reaching EXEC sets ILLEGAL sticky and moves the FSM to HALT.
  - In HALT all strobes are 0, INSTR_READY=0, and no PC_UPDATE occurs.
  - Only reset leaves HALT.
- Without the macro: NOP behaviour as above; no ILLEGAL port and no HALT state.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams OP_LOADI…OP_SWI;
  - ALUOP encodings ALU_FWD/ADD/AND/OR;
  - state encoding enum.
- Sub-module ctrl_decode: purely combinational opcode-to-static-controls decode (ALUOP, MUXCOMP, MUXIMM, is_mem, is_load, is_branch, legal). It is instantiated by control_fsm, which owns the state, IR and timeout counter.

Test Plan:
- sub (OPCODE=3) at edge T → ALUOP=1 and MUXCOMP=1 in T+1..T+2; WRITEENABLE=1 and PC_UPDATE=1 only in T+2; INSTR_READY=1 in T+3.
- beq (7) with ZERO=1, then beq with ZERO=0 → BRANCH_TAKEN=1 in EXEC, then 0; PC_UPDATE pulses both times.
- lwd (8) with BUSYWAIT high for 4 cycles → READ high 5 cycles; WB cycle has WRITEENABLE=1 and MUXMEM=1; PC_UPDATE once.
- swi (11), MEM_TIMEOUT=3, BUSYWAIT stuck at 1 → WRITE high 3 cycles, then MEM_ERR=1 and PC_UPDATE=1, no WRITEENABLE.
- RESET=0 asserted during a lwd stall → next cycle READ=0, INSTR_READY=1, no writeback; the following loadi (0) executes normally.
- OPCODE=0xFF → without the macro, PC_UPDATE only; with CTRL_ILLEGAL_TRAP_EN, ILLEGAL=1 and INSTR_READY stays 0 until reset.
